issue_dispatch_ctrl: RTL and testbench
======================================

# issue_dispatch_ctrl

Dispatch controller between rename and the 4-in/1-out issue queue. Accepts a 4-wide rename bundle with a per-lane valid mask and packs the valid lanes into the low queue input ports. Tracks issue-queue occupancy as credits and back-pressures rename when a full bundle might not fit. Drives the queue's write enable and handles pipeline flush recovery.

## Interface
- SIZE, 32, issue-queue slot count (≥4)
- WIDTH_I, 35, per-instruction payload width (matches queue input width)
- FLUSH_CYC, 2, dispatch-blocked cycles after a flush (≥1)
- CW, $clog2(SIZE+1), occupancy counter width (derived, not overridden)

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset; synchronous, active-high
- i_valid  in  4  per-lane valid of rename bundle, lane 0 = oldest
- i_inst  in  4*WIDTH_I  bundle payload, lane n at [n*WIDTH_I +: WIDTH_I]
- o_ready  out  1  bundle accepted this cycle if any i_valid set
- o_inst1..o_inst4  out  WIDTH_I each  packed payload to queue inputs 1..4
- o_en  out  1  queue write/shift enable
- i_issue  in  1  queue issued one instruction this cycle (frees one credit)
- i_flush  in  1  branch-kill/exception flush, queue contents discarded
- o_count  out  CW  current occupancy credit count
- o_underflow  out  1  sticky error: i_issue seen with count 0

## Operation
- States: FLUSH, RUN. Reset enters FLUSH with timer = FLUSH_CYC.
- Free = SIZE − count. o_ready = (state==RUN) && (Free ≥ 4); combinational from registers only, never from i_valid or i_issue.
- Accept = o_ready && |i_valid. On accept:
  - Packing: the k-th set bit of i_valid (scanning lane 0→3) goes to output port k+1; unused ports are driven all-zero. Relative order is preserved (e.g. mask 4'b1010 → lane1 to o_inst1, lane3 to o_inst2).
  - Output register loads the packed bundle; o_en = 1 next cycle.
- No accept: output register cleared to zero, o_en = 0 next cycle.
- Count update each edge: count + popcount(accepted mask) − (i_issue && count>0). Both events in the same cycle are applied together. The counter never exceeds SIZE and never wraps.
- i_issue with count==0: count holds at 0 and o_underflow sets. o_underflow clears only on i_rst.
- i_flush (any state, highest priority after i_rst): count ← 0, output register ← 0, o_en ← 0, state ← FLUSH, timer ← FLUSH_CYC. A bundle presented in the same cycle is dropped. i_issue in the same cycle is ignored and does not set o_underflow.
- FLUSH: o_ready = 0, timer decrements each cycle; at timer==1 → RUN. A new i_flush reloads the timer.

## Timing
- Reset values: o_ready 0, o_inst1..4 all-zero, o_en 0, o_count 0, o_underflow 0, state FLUSH, timer FLUSH_CYC.
- After i_rst deasserts at edge r, o_ready is first high in the cycle after edge r+FLUSH_CYC.
- Accept at edge k: o_en and o_inst valid during cycle k+1; o_count reflects the bundle from cycle k+1.
- o_ready is conservative: it requires 4 free credits regardless of bundle size. Same-cycle i_issue does not raise o_ready until the following cycle.
- Full boundary: count = SIZE−4 gives o_ready = 1; count = SIZE−3 gives o_ready = 0.
- Throughput: one bundle per cycle while Free ≥ 4.

## Test plan
- Reset, FLUSH_CYC=2: hold i_rst 3 cycles, release → o_ready=0 for 2 cycles then 1; all outputs zero throughout reset.
- Packing: i_valid=4'b1010, lanes 0..3 = 0x11,0x22,0x33,0x44 → next cycle o_en=1, o_inst1=0x22, o_inst2=0x44, o_inst3=o_inst4=0; o_count +2.
- Fill to full, SIZE=32: 7 bundles of mask 4'hF → count 28, o_ready=1; 8th bundle → count 32, o_ready=0. One i_issue → count 31, o_ready still 0. Three more issues → count 28, o_ready=1.
- Simultaneous events: count 10, accept mask 4'b0111 with i_issue=1 → count 12.
- Underflow: count 0, i_issue=1 → count stays 0, o_underflow=1 and stays set through later traffic.
- Flush mid-stream: count 20, i_valid=4'hF and i_flush together → no o_en next cycle, count 0, o_ready=0 for FLUSH_CYC cycles, then 1.

Source files
------------

// File: rtl/issue_dispatch_ctrl.sv
// Packs a 4-wide rename bundle into the issue-queue inputs and tracks queue occupancy as credits; 1-cycle latency.
// o_ready is registered-only and drops whenever fewer than 4 credits remain or during post-flush recovery.
module issue_dispatch_ctrl #(
   parameter  int SIZE      = 32,
   parameter  int WIDTH_I   = 35,
   parameter  int FLUSH_CYC = 2,
   localparam int CW        = $clog2(SIZE + 1)
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [3:0]             i_valid,
   input  logic [4*WIDTH_I-1:0]   i_inst,
   output logic                   o_ready,
   output logic [WIDTH_I-1:0]     o_inst1,
   output logic [WIDTH_I-1:0]     o_inst2,
   output logic [WIDTH_I-1:0]     o_inst3,
   output logic [WIDTH_I-1:0]     o_inst4,
   output logic                   o_en,
   input  logic                   i_issue,
   input  logic                   i_flush,
   output logic [CW-1:0]          o_count,
   output logic                   o_underflow
);

   localparam int TW = $clog2(FLUSH_CYC + 1);

   typedef enum logic {S_FLUSH, S_RUN} state_t;

   state_t               state, state_nx;
   logic [TW-1:0]        timer, timer_nx;
   logic [CW-1:0]        count, count_nx;
   logic                 underflow, underflow_nx;
   logic                 en, en_nx;
   logic [WIDTH_I-1:0]   slot    [4];
   logic [WIDTH_I-1:0]   slot_nx [4];
   logic                 accept;
   logic [2:0]           pop;
   logic [1:0]           k;
   logic                 dec;

   // Conservative: a full 4-lane bundle must always fit, regardless of the mask offered.
   assign o_ready = (state == S_RUN) && (count <= CW'(SIZE - 4));
   assign accept  = o_ready && (|i_valid);

   always_comb begin
      state_nx     = state;
      timer_nx     = timer;
      count_nx     = count;
      underflow_nx = underflow;
      en_nx        = 1'b0;
      for (int n = 0; n < 4; n++) slot_nx[n] = '0;
      pop = '0;
      k   = '0;
      dec = 1'b0;

      if (i_flush) begin
         state_nx = S_FLUSH;
         timer_nx = TW'(FLUSH_CYC);
         count_nx = '0;
      end else begin
         if (accept) begin
            en_nx = 1'b1;
            // k-th valid lane (oldest first) lands on port k+1
            for (int lane = 0; lane < 4; lane++) begin
               if (i_valid[lane]) begin
                  slot_nx[k] = i_inst[lane*WIDTH_I +: WIDTH_I];
                  k          = k + 2'd1;
                  pop        = pop + 3'd1;
               end
            end
         end
         if (i_issue) begin
            if (count == '0) underflow_nx = 1'b1;
            else             dec          = 1'b1;
         end
         count_nx = count + CW'(pop) - CW'(dec);
         if (state == S_FLUSH) begin
            if (timer == TW'(1)) state_nx = S_RUN;
            else                 timer_nx = timer - TW'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= S_FLUSH;
         timer     <= TW'(FLUSH_CYC);
         count     <= '0;
         underflow <= 1'b0;
         en        <= 1'b0;
         for (int n = 0; n < 4; n++) slot[n] <= '0;
      end else begin
         state     <= state_nx;
         timer     <= timer_nx;
         count     <= count_nx;
         underflow <= underflow_nx;
         en        <= en_nx;
         for (int n = 0; n < 4; n++) slot[n] <= slot_nx[n];
      end
   end

   assign o_inst1     = slot[0];
   assign o_inst2     = slot[1];
   assign o_inst3     = slot[2];
   assign o_inst4     = slot[3];
   assign o_en        = en;
   assign o_count     = count;
   assign o_underflow = underflow;

endmodule

// File: tb/tb_issue_dispatch_ctrl.sv
// Directed test-plan scenarios plus randomized traffic, checked every cycle against a queue-based reference model.
module tb_issue_dispatch_ctrl;

   localparam int SIZE      = 32;
   localparam int W         = 35;
   localparam int FLUSH_CYC = 2;
   localparam int CW        = $clog2(SIZE + 1);

   logic             i_clk;
   logic             i_rst;
   logic [3:0]       i_valid;
   logic [4*W-1:0]   i_inst;
   logic             o_ready;
   logic [W-1:0]     o_inst1, o_inst2, o_inst3, o_inst4;
   logic             o_en;
   logic             i_issue;
   logic             i_flush;
   logic [CW-1:0]    o_count;
   logic             o_underflow;

   issue_dispatch_ctrl #(.SIZE(SIZE), .WIDTH_I(W), .FLUSH_CYC(FLUSH_CYC)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_inst(i_inst),
      .o_ready(o_ready), .o_inst1(o_inst1), .o_inst2(o_inst2), .o_inst3(o_inst3),
      .o_inst4(o_inst4), .o_en(o_en), .i_issue(i_issue), .i_flush(i_flush),
      .o_count(o_count), .o_underflow(o_underflow)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   // Reference model: occupancy as an integer, flush recovery as "cycles still blocked".
   int           m_count   = 0;
   int           m_block   = FLUSH_CYC;
   bit           m_under   = 1'b0;
   bit           m_en      = 1'b0;
   logic [W-1:0] m_inst [4] = '{default: '0};

   function automatic bit m_ready();
      return (m_block == 0) && (SIZE - m_count >= 4);
   endfunction

   always @(posedge i_clk) begin
      logic [W-1:0] q[$];
      bit acc;
      int dec;
      if (i_rst) begin
         m_count = 0; m_block = FLUSH_CYC; m_under = 0; m_en = 0;
         for (int n = 0; n < 4; n++) m_inst[n] = '0;
      end else if (i_flush) begin
         m_count = 0; m_block = FLUSH_CYC; m_en = 0;
         for (int n = 0; n < 4; n++) m_inst[n] = '0;
      end else begin
         acc = m_ready() && (i_valid != 4'b0);
         q   = {};
         if (acc)
            for (int l = 0; l < 4; l++)
               if (i_valid[l]) q.push_back(i_inst[l*W +: W]);
         for (int n = 0; n < 4; n++) m_inst[n] = (n < q.size()) ? q[n] : '0;
         m_en = acc;
         dec  = 0;
         if (i_issue) begin
            if (m_count == 0) m_under = 1;
            else              dec = 1;
         end
         m_count = m_count + q.size() - dec;
         if (m_block > 0) m_block = m_block - 1;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   always @(negedge i_clk) begin
      if (chk_en) begin
         chk("ready",     64'(o_ready),     64'(m_ready()));
         chk("en",        64'(o_en),        64'(m_en));
         chk("count",     64'(o_count),     64'(m_count));
         chk("underflow", 64'(o_underflow), 64'(m_under));
         chk("inst1",     64'(o_inst1),     64'(m_inst[0]));
         chk("inst2",     64'(o_inst2),     64'(m_inst[1]));
         chk("inst3",     64'(o_inst3),     64'(m_inst[2]));
         chk("inst4",     64'(o_inst4),     64'(m_inst[3]));
      end
   end

   task automatic rand_inst();
      logic [63:0] r;
      for (int l = 0; l < 4; l++) begin
         r = {$urandom, $urandom};
         i_inst[l*W +: W] = r[W-1:0];
      end
   endtask

   // Drive inputs, then advance to the next falling edge where outputs are settled.
   task automatic tick(input logic [3:0] v, input logic iss, input logic fl);
      i_valid = v; i_issue = iss; i_flush = fl;
      @(negedge i_clk);
   endtask

   initial begin
      i_rst = 1'b1; i_valid = '0; i_issue = 0; i_flush = 0; i_inst = '0;
      @(negedge i_clk);
      chk_en = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick(4'h0, 0, 0);
         chk("rst_ready", 64'(o_ready), 64'd0);
         chk("rst_count", 64'(o_count), 64'd0);
         chk("rst_en",    64'(o_en),    64'd0);
         chk("rst_inst1", 64'(o_inst1), 64'd0);
      end
      i_rst = 1'b0;
      tick(4'h0, 0, 0);
      chk("post_rst_ready0", 64'(o_ready), 64'd0);
      tick(4'h0, 0, 0);
      chk("post_rst_ready1", 64'(o_ready), 64'd1);

      i_inst = '0;
      i_inst[0*W +: W] = 35'h11; i_inst[1*W +: W] = 35'h22;
      i_inst[2*W +: W] = 35'h33; i_inst[3*W +: W] = 35'h44;
      tick(4'b1010, 0, 0);
      chk("pack_en",    64'(o_en),    64'd1);
      chk("pack_inst1", 64'(o_inst1), 64'h22);
      chk("pack_inst2", 64'(o_inst2), 64'h44);
      chk("pack_inst3", 64'(o_inst3), 64'd0);
      chk("pack_inst4", 64'(o_inst4), 64'd0);
      chk("pack_count", 64'(o_count), 64'd2);
      tick(4'h0, 0, 0);
      chk("idle_en", 64'(o_en), 64'd0);

      tick(4'h0, 1, 0);
      tick(4'h0, 1, 0);
      chk("drain_count", 64'(o_count), 64'd0);
      for (int b = 0; b < 7; b++) begin rand_inst(); tick(4'hF, 0, 0); end
      chk("fill7_count", 64'(o_count), 64'd28);
      chk("fill7_ready", 64'(o_ready), 64'd1);
      rand_inst(); tick(4'hF, 0, 0);
      chk("fill8_count", 64'(o_count), 64'd32);
      chk("fill8_ready", 64'(o_ready), 64'd0);
      tick(4'h0, 1, 0);
      chk("full_iss_count", 64'(o_count), 64'd31);
      chk("full_iss_ready", 64'(o_ready), 64'd0);
      for (int c = 0; c < 3; c++) tick(4'h0, 1, 0);
      chk("reopen_count", 64'(o_count), 64'd28);
      chk("reopen_ready", 64'(o_ready), 64'd1);

      for (int c = 0; c < 18; c++) tick(4'h0, 1, 0);
      chk("pre_simul_count", 64'(o_count), 64'd10);
      rand_inst(); tick(4'b0111, 1, 0);
      chk("simul_count", 64'(o_count), 64'd12);

      for (int c = 0; c < 12; c++) tick(4'h0, 1, 0);
      chk("no_under_yet", 64'(o_underflow), 64'd0);
      tick(4'h0, 1, 0);
      chk("under_count", 64'(o_count), 64'd0);
      chk("under_flag",  64'(o_underflow), 64'd1);

      for (int b = 0; b < 5; b++) begin rand_inst(); tick(4'hF, 0, 0); end
      chk("pre_flush_count", 64'(o_count), 64'd20);
      rand_inst(); tick(4'hF, 1, 1);
      chk("flush_en",    64'(o_en),        64'd0);
      chk("flush_count", 64'(o_count),     64'd0);
      chk("flush_ready", 64'(o_ready),     64'd0);
      chk("flush_under", 64'(o_underflow), 64'd1);
      tick(4'h0, 0, 0);
      chk("flush_rec0", 64'(o_ready), 64'd0);
      tick(4'h0, 0, 0);
      chk("flush_rec1", 64'(o_ready), 64'd1);

      for (int c = 0; c < 3000; c++) begin
         rand_inst();
         i_rst = ($urandom_range(0, 299) == 0);
         tick(($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
              ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 59) == 0));
      end
      i_rst = 1'b0;
      tick(4'h0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
